// File: rtl/tile_rotation_ctrl_if.sv
// Request/status bundle between the key decoder, frame pacer and tile rotation controller.
// master drives pacing and key requests; slave returns per-tile orientation and status.
interface tile_rotation_ctrl_if #(
    parameter int N_TILES = 12
);
    logic                 tick;
    logic                 hold;
    logic                 key_valid;
    logic [3:0]           key_tile;
    logic                 key_ccw;
    logic [2*N_TILES-1:0] rot_state;
    logic [3:0]           active_tile;
    logic                 anim_busy;
    logic                 shuffling;
    logic                 pass;

    modport master (
        output tick, hold, key_valid, key_tile, key_ccw,
        input  rot_state, active_tile, anim_busy, shuffling, pass
    );

    modport slave (
        input  tick, hold, key_valid, key_tile, key_ccw,
        output rot_state, active_tile, anim_busy, shuffling, pass
    );
endinterface

// File: rtl/tile_rotation_ctrl.sv
// Per-tile orientation store: LFSR scramble after reset, then one rotation per request, committed ANIM_TICKS ticks later.
// Requests arriving while busy, held, solved or out of range are dropped (no queueing); hold freezes the tick count.
module tile_rotation_ctrl #(
    parameter int          N_TILES    = 12,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          ANIM_TICKS = 4
) (
    input  logic                clk,
    input  logic                rst,
    tile_rotation_ctrl_if.slave bus
);
    typedef enum logic [1:0] {SHUFFLE, FIXUP, IDLE, WAIT} state_t;

    localparam logic [3:0] LAST_IDX  = 4'(N_TILES - 1);
    localparam logic [4:0] N_TILES_W = 5'(N_TILES);
    localparam logic [3:0] LAST_TICK = 4'(ANIM_TICKS - 1);

    state_t               state;
    logic [1:0]           rot_q [N_TILES];
    logic [15:0]          lfsr;
    logic [3:0]           idx;
    logic [3:0]           tick_cnt;
    logic [3:0]           tile_q;
    logic                 ccw_q;
    logic [3:0]           active_q;
    logic                 busy_q;
    logic                 shuf_q;
    logic                 pass_q;
    logic [2*N_TILES-1:0] rot_flat;
    logic                 lfsr_fb;
    logic                 all_zero;
    logic                 accept;

    always_comb begin
        rot_flat = '0;
        for (int t = 0; t < N_TILES; t++) begin
            rot_flat[2*t +: 2] = rot_q[t];
        end
    end

    assign all_zero = (rot_flat == '0);
    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign accept   = bus.key_valid && !bus.hold && !pass_q &&
                      ({1'b0, bus.key_tile} < N_TILES_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < N_TILES; t++) begin
                rot_q[t] <= 2'd0;
            end
            state    <= SHUFFLE;
            lfsr     <= LFSR_SEED;
            idx      <= 4'd0;
            tick_cnt <= 4'd0;
            tile_q   <= 4'd0;
            ccw_q    <= 1'b0;
            active_q <= 4'd0;
            busy_q   <= 1'b0;
            shuf_q   <= 1'b1;
            pass_q   <= 1'b0;
        end else begin
            case (state)
                SHUFFLE: begin
                    rot_q[idx] <= lfsr[1:0];
                    lfsr       <= {lfsr[14:0], lfsr_fb};
                    idx        <= idx + 4'd1;
                    if (idx == LAST_IDX) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    // A scramble that lands fully upright would start solved; nudge tile 0.
                    if (all_zero) begin
                        rot_q[0] <= 2'd1;
                    end
                    shuf_q <= 1'b0;
                    state  <= IDLE;
                end
                IDLE: begin
                    pass_q <= pass_q | all_zero;
                    if (accept) begin
                        tile_q   <= bus.key_tile;
                        ccw_q    <= bus.key_ccw;
                        active_q <= bus.key_tile;
                        busy_q   <= 1'b1;
                        tick_cnt <= 4'd0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.tick && !bus.hold) begin
                        if (tick_cnt == LAST_TICK) begin
                            rot_q[tile_q] <= ccw_q ? rot_q[tile_q] - 2'd1
                                                   : rot_q[tile_q] + 2'd1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                default: state <= SHUFFLE;
            endcase
        end
    end

    assign bus.rot_state   = rot_flat;
    assign bus.active_tile = active_q;
    assign bus.anim_busy   = busy_q;
    assign bus.shuffling   = shuf_q;
    assign bus.pass        = pass_q;

    a_busy_in_wait: assert property (@(posedge clk) disable iff (rst)
        busy_q == (state == WAIT));
    a_shuf_early: assert property (@(posedge clk) disable iff (rst)
        shuf_q == (state == SHUFFLE || state == FIXUP));
endmodule

// File: tb/tb_tile_rotation_ctrl.sv
// Directed bench for tile_rotation_ctrl: scramble, rotations with wrap, dropped requests, hold, solve and reset-abort.
module tb_tile_rotation_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tile_rotation_ctrl_if #(.N_TILES(12)) bus ();

    tile_rotation_ctrl #(
        .N_TILES   (12),
        .LFSR_SEED (16'hACE1),
        .ANIM_TICKS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] model [12];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pack_model();
        logic [23:0] v;
        for (int t = 0; t < 12; t++) v[2*t +: 2] = model[t];
        return v;
    endfunction

    // Hand-derived scramble from seed ACE1: low two bits of ACE1, 59C3, B387, 670F, CE1E, 9C3C, 3879, 70F2, E1E4, C3C8, 8791, 0F22.
    task automatic load_scramble();
        model = '{2'd1, 2'd3, 2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2};
    endtask

    task automatic wait_shuffle(output int cycles, output bit pass_seen);
        cycles    = 0;
        pass_seen = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (bus.pass) pass_seen = 1;
        end while (bus.shuffling && cycles < 40);
    endtask

    task automatic tick1();
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
    endtask

    task automatic key(input int t, input bit ccw, input bit hold_lvl, input bit tick_lvl);
        bus.key_valid = 1'b1;
        bus.key_tile  = 4'(t);
        bus.key_ccw   = ccw;
        bus.hold      = hold_lvl;
        bus.tick      = tick_lvl;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.hold      = 1'b0;
        bus.tick      = 1'b0;
    endtask

    task automatic do_rot(input int t, input bit ccw, input bit tick_on_acc, input string tag);
        key(t, ccw, 1'b0, tick_on_acc);
        check({tag, "_busy_acc"}, bus.anim_busy, 1);
        check({tag, "_active"}, bus.active_tile, t);
        for (int k = 1; k <= 4; k++) begin
            tick1();
            check({tag, "_busy"}, bus.anim_busy, (k < 4) ? 1 : 0);
        end
        model[t] = ccw ? model[t] - 2'd1 : model[t] + 2'd1;
        check({tag, "_rot"}, bus.rot_state, pack_model());
    endtask

    initial begin
        int cycles;
        bit pass_seen;
        int last_t;

        bus.tick      = 1'b0;
        bus.hold      = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_tile  = 4'd0;
        bus.key_ccw   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_rot", bus.rot_state, 0);
        check("rst_active", bus.active_tile, 0);
        check("rst_busy", bus.anim_busy, 0);
        check("rst_shuf", bus.shuffling, 1);
        check("rst_pass", bus.pass, 0);

        rst = 1'b0;
        wait_shuffle(cycles, pass_seen);
        load_scramble();
        check("shuf_cycles", cycles, 13);
        check("shuf_pass", pass_seen, 0);
        check("shuf_t0", bus.rot_state[1:0], 1);
        check("shuf_t1", bus.rot_state[3:2], 3);
        check("shuf_rot", bus.rot_state, pack_model());

        // Tick in the acceptance cycle must not count toward the four.
        do_rot(5, 1'b0, 1'b1, "t5cw");
        check("t5_field", bus.rot_state[11:10], 1);

        do_rot(2, 1'b0, 1'b0, "t2cw_wrap");
        check("t2_zero", bus.rot_state[5:4], 0);
        do_rot(2, 1'b1, 1'b0, "t2ccw_wrap");
        check("t2_three", bus.rot_state[5:4], 3);
        do_rot(3, 1'b0, 1'b0, "t3cw_wrap");
        check("t3_zero", bus.rot_state[7:6], 0);

        key(12, 1'b0, 1'b0, 1'b0);
        check("oor_busy", bus.anim_busy, 0);
        check("oor_active", bus.active_tile, 3);
        key(7, 1'b0, 1'b1, 1'b0);
        check("hold_key_busy", bus.anim_busy, 0);
        check("hold_key_active", bus.active_tile, 3);
        key(4, 1'b0, 1'b0, 1'b0);
        check("t4_busy_acc", bus.anim_busy, 1);
        key(9, 1'b1, 1'b0, 1'b0);
        check("wait_key_active", bus.active_tile, 4);
        repeat (3) tick1();
        check("t4_busy3", bus.anim_busy, 1);
        tick1();
        check("t4_busy_done", bus.anim_busy, 0);
        model[4] = model[4] + 2'd1;
        check("t4_rot", bus.rot_state, pack_model());
        @(negedge clk);
        check("no_queue_busy", bus.anim_busy, 0);
        check("no_queue_active", bus.active_tile, 4);

        key(6, 1'b0, 1'b0, 1'b0);
        repeat (2) tick1();
        bus.hold = 1'b1;
        repeat (3) tick1();
        bus.hold = 1'b0;
        check("hold_frozen", bus.anim_busy, 1);
        tick1();
        check("hold_third", bus.anim_busy, 1);
        tick1();
        check("hold_commit", bus.anim_busy, 0);
        model[6] = model[6] + 2'd1;
        check("t6_rot", bus.rot_state, pack_model());

        last_t = 0;
        for (int t = 0; t < 12; t++) begin
            while (model[t] != 2'd0) begin
                do_rot(t, model[t] == 2'd1, 1'b0, "solve");
                last_t = t;
            end
        end
        check("solve_rot", bus.rot_state, 0);
        check("pass_commit_edge", bus.pass, 0);
        @(negedge clk);
        check("pass_rise", bus.pass, 1);
        key(0, 1'b0, 1'b0, 1'b0);
        check("solved_busy", bus.anim_busy, 0);
        check("solved_active", bus.active_tile, last_t);
        repeat (5) tick1();
        check("solved_rot", bus.rot_state, 0);
        check("solved_pass", bus.pass, 1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_shuffle(cycles, pass_seen);
        load_scramble();
        check("rerun_cycles", cycles, 13);
        check("rerun_rot", bus.rot_state, pack_model());
        check("rerun_pass", bus.pass, 0);
        key(0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick1();
        rst      = 1'b1;
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wait_shuffle(cycles, pass_seen);
        check("abort_cycles", cycles, 13);
        check("abort_rot", bus.rot_state, pack_model());
        check("abort_busy", bus.anim_busy, 0);
        check("abort_active", bus.active_tile, 0);
        repeat (4) tick1();
        check("abort_no_commit", bus.rot_state, pack_model());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
